gpio_vector_runner: RTL

- Synthesizable, parametrised stimulus/response engine for CPU GPIO bring-up.
- Fetches packed test vectors from an external synchronous ROM and drives the DUT reset and gpio_in, holding each vector for a configurable number of cycles.
- Compares masked DUT gpio_out against the expected value and reports an error count, a vector count and the first failing address.
- Lets the lab CPUs be self-checked on the board and in simulation from the same vector image.

---
 rtl/gpio_vector_runner.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gpio_vector_runner.sv
// gpio_vector_runner
// ------------------
// Stimulus/response engine for CPU GPIO bring-up. It walks a vector image
// held in an external synchronous ROM. For each vector it drives the DUT
// reset and gpio_in, holds them for a number of cycles, and can compare the
// masked DUT gpio_out against an expected value. It reports a vector count,
// an error count and the address of the first failing vector.
//
// Vector word, MSB to LSB: flags[3:0], in[W-1:0], exp[W-1:0], mask[W-1:0]
//   flags[0] dut_rst value, flags[1] check enable, flags[2] end marker,
//   flags[3] reserved
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         single-cycle pulse, begins a run at address 0
//   vec_rd        ROM read strobe
//   vec_addr      ROM address
//   vec_data      ROM word, valid the cycle after vec_rd
//   dut_rst       reset driven to the DUT
//   dut_gpio_in   stimulus driven to the DUT
//   dut_gpio_out  DUT response
//   busy          run in progress
//   done          run finished, sticky until the next start or rst
//   pass          valid while done=1, set when no mismatches were seen
//   err_count     saturating mismatch count
//   vec_count     saturating count of vectors applied
//   fail_addr     address of the first mismatching vector
//   fail_valid    fail_addr is meaningful
module gpio_vector_runner #(
    parameter int W          = 32,
    parameter int AW         = 20,
    parameter int RUN_CYCLES = 70,
    parameter int RST_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 vec_rd,
    output logic [AW-1:0]        vec_addr,
    input  logic [4+3*W-1:0]     vec_data,
    output logic                 dut_rst,
    output logic [W-1:0]         dut_gpio_in,
    input  logic [W-1:0]         dut_gpio_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     vec_count,
    output logic [AW-1:0]        fail_addr,
    output logic                 fail_valid
);

    // The hold counter only has to reach the larger of the two hold lengths.
    localparam int HOLD_MAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int HCW      = $clog2(HOLD_MAX + 1);

    localparam logic [HCW-1:0]   RUN_LOAD  = HCW'(RUN_CYCLES);
    localparam logic [HCW-1:0]   RST_LOAD  = HCW'(RST_CYCLES);
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(1);
    localparam logic [AW-1:0]    LAST_ADDR = '1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state;
    logic [HCW-1:0]   hold_cnt;
    logic             cur_check;
    logic [W-1:0]     cur_exp;
    logic [W-1:0]     cur_mask;

    // Field views of the ROM word.
    logic             f_rst;
    logic             f_check;
    logic             f_end;
    logic [W-1:0]     f_in;
    logic [W-1:0]     f_exp;
    logic [W-1:0]     f_mask;
    logic             unused_flag;

    assign f_rst       = vec_data[3*W];
    assign f_check     = vec_data[3*W+1];
    assign f_end       = vec_data[3*W+2];
    assign unused_flag = vec_data[3*W+3];
    assign f_in        = vec_data[3*W-1 -: W];
    assign f_exp       = vec_data[2*W-1 -: W];
    assign f_mask      = vec_data[W-1:0];

    // Compare result for the vector currently being held. cur_check is
    // already cleared for reset vectors, so they can never count as errors.
    logic             mismatch;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W-1:0] vec_next;

    assign mismatch = cur_check && (|((dut_gpio_out ^ cur_exp) & cur_mask));
    assign err_next = (mismatch && (err_count != CNT_MAX)) ? err_count + CNT_ONE : err_count;
    assign vec_next = (vec_count != CNT_MAX) ? vec_count + CNT_ONE : vec_count;

    // Run sequencer. vec_addr doubles as the vector index; every output is a
    // register so nothing combinational reaches the pins. Entering FETCH
    // raises vec_rd in the same edge so the strobe is high for exactly the
    // FETCH cycle and the ROM word is ready during LATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            vec_rd      <= 1'b0;
            vec_addr    <= '0;
            dut_rst     <= 1'b1;
            dut_gpio_in <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            vec_count   <= '0;
            fail_addr   <= '0;
            fail_valid  <= 1'b0;
            hold_cnt    <= '0;
            cur_check   <= 1'b0;
            cur_exp     <= '0;
            cur_mask    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        vec_rd     <= 1'b1;
                        vec_addr   <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        vec_count  <= '0;
                        fail_addr  <= '0;
                        fail_valid <= 1'b0;
                    end
                end

                S_FETCH: begin
                    vec_rd <= 1'b0;
                    state  <= S_LATCH;
                end

                S_LATCH: begin
                    if (f_end) begin
                        // End marker: leave the DUT pins exactly as they are.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        dut_rst     <= f_rst;
                        dut_gpio_in <= f_in;
                        cur_check   <= f_check && !f_rst;
                        cur_exp     <= f_exp;
                        cur_mask    <= f_mask;
                        hold_cnt    <= f_rst ? RST_LOAD : RUN_LOAD;
                        state       <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // Last hold cycle: the DUT has had the full hold
                        // time to settle, so this is where it is judged.
                        err_count <= err_next;
                        vec_count <= vec_next;
                        if (mismatch && !fail_valid) begin
                            fail_addr  <= vec_addr;
                            fail_valid <= 1'b1;
                        end
                        if (vec_addr == LAST_ADDR) begin
                            // The index never wraps; the top address ends the run.
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            vec_addr <= vec_addr + AW'(1);
                            vec_rd   <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_LAST;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
